video_dnn_number_histogram: RTL and testbench
=============================================

# video_dnn_number_histogram

Sink for the per-pixel classification stream produced by the MNIST detection/max-count pipeline (tnumber/tcount/tdetection per pixel). Accumulates, per video frame, a histogram of pixels confidently classified as each digit class, plus line/pixel counts. At every frame start it latches the finished histogram into shadow registers readable over a single-clock Wishbone slave. This lets software poll per-frame recognition results without touching the video path.

## Interface
- TUSER_WIDTH, 1: user sideband width; bit 0 = start of frame
- TNUMBER_WIDTH, 4: class index width
- TCOUNT_WIDTH, 4: vote-count width
- NUM_CLASS, 11: classes 0..NUM_CLASS-1; class NUM_CLASS-1 is background and never counted
- HIST_WIDTH, 24: histogram, line and pixel counter width (≤ WB_DAT_WIDTH)
- WB_ADR_WIDTH, 8: Wishbone word-address width
- WB_DAT_WIDTH, 32: Wishbone data width
- WB_SEL_WIDTH, WB_DAT_WIDTH/8: byte-select width
- INIT_PARAM_COUNT_TH, 4: reset value of the count threshold
- aclk  in  1  single clock for stream and Wishbone
- aresetn  in  1  asynchronous, active-low reset
- s_axi4s_tuser  in  TUSER_WIDTH  bit 0 = first pixel of frame
- s_axi4s_tlast  in  1  last pixel of line
- s_axi4s_tnumber  in  TNUMBER_WIDTH  winning class
- s_axi4s_tcount  in  TCOUNT_WIDTH  votes for winning class
- s_axi4s_tdetection  in  1  detection-window valid flag
- s_axi4s_tvalid  in  1  beat valid
- s_axi4s_tready  out  1  registered; 0 in reset, 1 otherwise
- s_wb_adr_i  in  WB_ADR_WIDTH  word address
- s_wb_dat_i  in  WB_DAT_WIDTH  write data
- s_wb_dat_o  out  WB_DAT_WIDTH  read data, combinational from address
- s_wb_we_i  in  1  write enable
- s_wb_sel_i  in  WB_SEL_WIDTH  byte enables
- s_wb_stb_i  in  1  strobe
- s_wb_ack_o  out  1  = s_wb_stb_i (zero-wait)

## Operation
- Beat accepted when tvalid & tready. A beat with tuser[0]=0 before the first tuser[0]=1 since reset is discarded (started flag = 0).
- Counted beat: started & ENABLE & tdetection & (tcount ≥ COUNT_TH) & (tnumber < NUM_CLASS-1) → work_hist[tnumber] += 1, saturating at 2^HIST_WIDTH-1. tnumber ≥ NUM_CLASS-1 is never counted.
- Every accepted beat after start: work_pixels += 1; tlast adds 1 to work_lines; both saturate.
- Frame start (accepted beat, tuser[0]=1):
  - If started & !FREEZE: shadow ← work registers, FRAME_COUNT += 1 (wraps mod 2^WB_DAT_WIDTH), VALID ← 1.
  - Work registers are reset to the contribution of this beat alone (the pixel belongs to the new frame). started ← 1.
- ENABLE gates histogram increments only; pixel/line counting and frame latching continue.
- FREEZE holds the shadow registers and FRAME_COUNT; the work registers still accumulate and clear.
- Register map (word addresses; unlisted addresses read 0; writes to RO registers are ignored):
  - 0x00 STATUS, RO: bit0 VALID
  - 0x01 FRAME_COUNT, RO
  - 0x02 CONTROL, RW: bit0 ENABLE (reset 1), bit1 FREEZE (reset 0)
  - 0x03 COUNT_TH, RW: [TCOUNT_WIDTH-1:0]
  - 0x04 LINES, RO: shadow line count
  - 0x05 PIXELS, RO: shadow pixel count
  - 0x10+k HIST[k], RO: k = 0..NUM_CLASS-2
- Writes: on stb & we, each byte lane i updates only if sel[i]=1. Register bits wider than the field are ignored and read as 0.

## Timing
- Reset values: tready=0, all counters/shadows/FRAME_COUNT/VALID/started=0, ENABLE=1, FREEZE=0, COUNT_TH=INIT_PARAM_COUNT_TH. s_wb_dat_o reflects these; s_wb_ack_o follows stb even during reset.
- tready rises on the first aclk edge after aresetn deasserts and then stays high (no backpressure).
- Latency: beat at edge N is reflected in the work registers after edge N. The shadow update caused by a tuser beat at edge N is readable from cycle N+1. A Wishbone read in the same cycle as the latching edge returns the old value.
- A CONTROL or COUNT_TH write at edge N governs beats accepted at edge N+1 onward; a beat at edge N uses the old values.
- Asserting reset mid-frame discards all state; counting resumes only after the next tuser beat.

## Test plan
- Reset, then 2 frames of 4×3 pixels, all beats tnumber=3, tcount=8, tdetection=1, with a tuser beat opening frame 3 → HIST[3]=12, PIXELS=12, LINES=3, FRAME_COUNT=2, VALID=1.
- Same frame but tcount=3 with COUNT_TH=4, plus tnumber=10 beats and tdetection=0 beats → all HIST=0, PIXELS=12.
- 5 beats before the first tuser, then a 12-pixel frame of tnumber=7 → HIST[7]=12, not 17.
- FREEZE=1 before frame 2 (tnumber=5) closes → HIST[5] still shows frame-1 value and FRAME_COUNT unchanged. Clear FREEZE; after frame 3 closes, HIST reflects frame 3 only.
- HIST_WIDTH=4, 20 counted tnumber=1 beats → HIST[1]=15. Write COUNT_TH=0x12345678 with sel=4'b0001 → reads 0x8.
- Assert aresetn low mid-frame → tready=0 and all registers read reset values. After release, beats before the next tuser are not counted.

Source files
------------

// File: rtl/video_dnn_number_histogram.sv
// Per-frame histogram of confidently classified pixels from the MNIST pipeline,
// latched into shadow registers at each frame start and read over Wishbone.
module video_dnn_number_histogram #(
   parameter int TUSER_WIDTH         = 1,
   parameter int TNUMBER_WIDTH       = 4,
   parameter int TCOUNT_WIDTH        = 4,
   parameter int NUM_CLASS           = 11,
   parameter int HIST_WIDTH          = 24,
   parameter int WB_ADR_WIDTH        = 8,
   parameter int WB_DAT_WIDTH        = 32,
   parameter int WB_SEL_WIDTH        = WB_DAT_WIDTH / 8,
   parameter int INIT_PARAM_COUNT_TH = 4
) (
   input  logic                     aclk,
   input  logic                     aresetn,
   input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
   input  logic                     s_axi4s_tlast,
   input  logic [TNUMBER_WIDTH-1:0] s_axi4s_tnumber,
   input  logic [TCOUNT_WIDTH-1:0]  s_axi4s_tcount,
   input  logic                     s_axi4s_tdetection,
   input  logic                     s_axi4s_tvalid,
   output logic                     s_axi4s_tready,
   input  logic [WB_ADR_WIDTH-1:0]  s_wb_adr_i,
   input  logic [WB_DAT_WIDTH-1:0]  s_wb_dat_i,
   output logic [WB_DAT_WIDTH-1:0]  s_wb_dat_o,
   input  logic                     s_wb_we_i,
   input  logic [WB_SEL_WIDTH-1:0]  s_wb_sel_i,
   input  logic                     s_wb_stb_i,
   output logic                     s_wb_ack_o
);

   localparam int HN = NUM_CLASS - 1;
   localparam logic [HIST_WIDTH-1:0] HMAX = '1;

   logic                    tready_q;
   logic                    started;
   logic                    enable;
   logic                    freeze;
   logic                    valid;
   logic [TCOUNT_WIDTH-1:0] count_th;
   logic [WB_DAT_WIDTH-1:0] frame_count;
   logic [HIST_WIDTH-1:0]   work_hist   [HN];
   logic [HIST_WIDTH-1:0]   shadow_hist [HN];
   logic [HIST_WIDTH-1:0]   work_lines;
   logic [HIST_WIDTH-1:0]   work_pixels;
   logic [HIST_WIDTH-1:0]   shadow_lines;
   logic [HIST_WIDTH-1:0]   shadow_pixels;

   logic beat;
   logic sof;
   logic active;
   logic counted;
   logic wb_wr;
   logic [WB_DAT_WIDTH-1:0] ctrl_word;
   logic [WB_DAT_WIDTH-1:0] ctrl_new;
   logic [WB_DAT_WIDTH-1:0] th_new;

   function automatic logic [HIST_WIDTH-1:0] sat_inc(input logic [HIST_WIDTH-1:0] v);
      return (v == HMAX) ? v : v + HIST_WIDTH'(1);
   endfunction

   function automatic logic [WB_DAT_WIDTH-1:0] wb_merge(
      input logic [WB_DAT_WIDTH-1:0] old,
      input logic [WB_DAT_WIDTH-1:0] dat,
      input logic [WB_SEL_WIDTH-1:0] sel
   );
      logic [WB_DAT_WIDTH-1:0] r;
      r = old;
      for (int i = 0; i < WB_SEL_WIDTH; i++)
         if (sel[i]) r[8*i +: 8] = dat[8*i +: 8];
      return r;
   endfunction

   assign s_axi4s_tready = tready_q;
   assign s_wb_ack_o     = s_wb_stb_i;

   // A tuser beat always opens a frame, even before the first start has been seen.
   assign beat    = s_axi4s_tvalid & tready_q;
   assign sof     = beat & s_axi4s_tuser[0];
   assign active  = sof | (beat & started);
   assign counted = active & enable & s_axi4s_tdetection
                  & (s_axi4s_tcount >= count_th)
                  & (int'(s_axi4s_tnumber) < HN);

   assign wb_wr     = s_wb_stb_i & s_wb_we_i;
   assign ctrl_word = {{(WB_DAT_WIDTH-2){1'b0}}, freeze, enable};
   assign ctrl_new  = wb_merge(ctrl_word, s_wb_dat_i, s_wb_sel_i);
   assign th_new    = wb_merge(WB_DAT_WIDTH'(count_th), s_wb_dat_i, s_wb_sel_i);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) tready_q <= 1'b0;
      else          tready_q <= 1'b1;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         enable   <= 1'b1;
         freeze   <= 1'b0;
         count_th <= TCOUNT_WIDTH'(INIT_PARAM_COUNT_TH);
      end else if (wb_wr) begin
         if (s_wb_adr_i == WB_ADR_WIDTH'(2)) begin
            enable <= ctrl_new[0];
            freeze <= ctrl_new[1];
         end
         if (s_wb_adr_i == WB_ADR_WIDTH'(3))
            count_th <= th_new[TCOUNT_WIDTH-1:0];
      end
   end

   // The opening beat of a frame seeds the work counters with its own contribution.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         started       <= 1'b0;
         valid         <= 1'b0;
         frame_count   <= '0;
         work_lines    <= '0;
         work_pixels   <= '0;
         shadow_lines  <= '0;
         shadow_pixels <= '0;
         for (int k = 0; k < HN; k++) begin
            work_hist[k]   <= '0;
            shadow_hist[k] <= '0;
         end
      end else if (sof) begin
         if (started && !freeze) begin
            shadow_hist   <= work_hist;
            shadow_lines  <= work_lines;
            shadow_pixels <= work_pixels;
            frame_count   <= frame_count + WB_DAT_WIDTH'(1);
            valid         <= 1'b1;
         end
         started     <= 1'b1;
         work_pixels <= HIST_WIDTH'(1);
         work_lines  <= s_axi4s_tlast ? HIST_WIDTH'(1) : '0;
         for (int k = 0; k < HN; k++)
            work_hist[k] <= (counted && int'(s_axi4s_tnumber) == k) ? HIST_WIDTH'(1) : '0;
      end else if (active) begin
         work_pixels <= sat_inc(work_pixels);
         if (s_axi4s_tlast) work_lines <= sat_inc(work_lines);
         for (int k = 0; k < HN; k++)
            if (counted && int'(s_axi4s_tnumber) == k)
               work_hist[k] <= sat_inc(work_hist[k]);
      end
   end

   always_comb begin
      s_wb_dat_o = '0;
      case (s_wb_adr_i)
         WB_ADR_WIDTH'(0): s_wb_dat_o[0]   = valid;
         WB_ADR_WIDTH'(1): s_wb_dat_o      = frame_count;
         WB_ADR_WIDTH'(2): s_wb_dat_o[1:0] = {freeze, enable};
         WB_ADR_WIDTH'(3): s_wb_dat_o      = WB_DAT_WIDTH'(count_th);
         WB_ADR_WIDTH'(4): s_wb_dat_o      = WB_DAT_WIDTH'(shadow_lines);
         WB_ADR_WIDTH'(5): s_wb_dat_o      = WB_DAT_WIDTH'(shadow_pixels);
         default: begin
            for (int k = 0; k < HN; k++)
               if (s_wb_adr_i == WB_ADR_WIDTH'(16 + k))
                  s_wb_dat_o = WB_DAT_WIDTH'(shadow_hist[k]);
         end
      endcase
   end

endmodule

// File: tb/tb_video_dnn_number_histogram.sv
// Bench for video_dnn_number_histogram: a default instance plus a 4-bit-counter
// instance sharing the same stimulus, register reads checked through a scoreboard.
module tb_video_dnn_number_histogram;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [0:0]  tuser = '0;
   logic        tlast = 1'b0;
   logic [3:0]  tnumber = '0;
   logic [3:0]  tcount = '0;
   logic        tdetection = 1'b0;
   logic        tvalid = 1'b0;
   logic        tready, tready4;
   logic [7:0]  wb_adr = '0;
   logic [31:0] wb_dat_i = '0;
   logic [31:0] wb_dat, wb_dat4;
   logic        wb_we = 1'b0;
   logic [3:0]  wb_sel = '0;
   logic        wb_stb = 1'b0;
   logic        wb_ack, wb_ack4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]  adr;
      logic [31:0] exp;
      bit          alt;
      string       name;
   } rd_vec_t;

   rd_vec_t     tbl[$];
   logic [31:0] exp_q[$];

   always #5 aclk = ~aclk;

   video_dnn_number_histogram dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_axi4s_tuser(tuser), .s_axi4s_tlast(tlast), .s_axi4s_tnumber(tnumber),
      .s_axi4s_tcount(tcount), .s_axi4s_tdetection(tdetection),
      .s_axi4s_tvalid(tvalid), .s_axi4s_tready(tready),
      .s_wb_adr_i(wb_adr), .s_wb_dat_i(wb_dat_i), .s_wb_dat_o(wb_dat),
      .s_wb_we_i(wb_we), .s_wb_sel_i(wb_sel), .s_wb_stb_i(wb_stb), .s_wb_ack_o(wb_ack)
   );

   video_dnn_number_histogram #(.HIST_WIDTH(4)) dut4 (
      .aclk(aclk), .aresetn(aresetn),
      .s_axi4s_tuser(tuser), .s_axi4s_tlast(tlast), .s_axi4s_tnumber(tnumber),
      .s_axi4s_tcount(tcount), .s_axi4s_tdetection(tdetection),
      .s_axi4s_tvalid(tvalid), .s_axi4s_tready(tready4),
      .s_wb_adr_i(wb_adr), .s_wb_dat_i(wb_dat_i), .s_wb_dat_o(wb_dat4),
      .s_wb_we_i(wb_we), .s_wb_sel_i(wb_sel), .s_wb_stb_i(wb_stb), .s_wb_ack_o(wb_ack4)
   );

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
      end
   endtask

   task automatic expectRead(input logic [7:0] adr, input logic [31:0] exp, input bit alt, input string name);
      tbl.push_back('{adr, exp, alt, name});
   endtask

   // Each queued read pushes its expectation when driven and pops it when sampled.
   task automatic runTable();
      logic [31:0] got;
      logic [31:0] e;
      for (int i = 0; i < tbl.size(); i++) begin
         exp_q.push_back(tbl[i].exp);
         @(negedge aclk);
         wb_adr = tbl[i].adr;
         wb_we  = 1'b0;
         wb_stb = 1'b1;
         #1;
         got = tbl[i].alt ? wb_dat4 : wb_dat;
         e   = exp_q.pop_front();
         checkOutput(tbl[i].name, got, e);
         wb_stb = 1'b0;
      end
      tbl.delete();
   endtask

   task automatic wbWrite(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel);
      @(negedge aclk);
      wb_adr = adr; wb_dat_i = dat; wb_sel = sel; wb_we = 1'b1; wb_stb = 1'b1;
      @(posedge aclk);
      #1;
      wb_we = 1'b0; wb_stb = 1'b0; wb_sel = '0;
   endtask

   task automatic applyStimulus(input bit tu, input bit tl, input int num, input int cnt, input bit det);
      @(negedge aclk);
      tuser = tu; tlast = tl; tnumber = 4'(num); tcount = 4'(cnt); tdetection = det;
      tvalid = 1'b1;
      @(posedge aclk);
      #1;
      tvalid = 1'b0;
   endtask

   // mix cycles through three beat kinds that must never be counted.
   task automatic sendFrame(input int w, input int h, input int first,
                            input int num, input int cnt, input bit det, input bit mix);
      for (int i = first; i < w * h; i++) begin
         if (!mix)             applyStimulus(i == 0, (i % w) == w - 1, num, cnt, det);
         else if (i % 3 == 0)  applyStimulus(i == 0, (i % w) == w - 1, num, 3, 1'b1);
         else if (i % 3 == 1)  applyStimulus(i == 0, (i % w) == w - 1, 10, 8, 1'b1);
         else                  applyStimulus(i == 0, (i % w) == w - 1, num, 8, 1'b0);
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      // Reset values, including ack following stb while held in reset.
      repeat (2) @(negedge aclk);
      checkOutput("tready_in_reset", {31'b0, tready}, 32'd0);
      wb_adr = 8'h00; wb_stb = 1'b1;
      #1 checkOutput("ack_in_reset", {31'b0, wb_ack}, 32'd1);
      wb_stb = 1'b0;
      expectRead(8'h00, 32'd0, 0, "status_rst");
      expectRead(8'h01, 32'd0, 0, "frame_count_rst");
      expectRead(8'h02, 32'd1, 0, "control_rst");
      expectRead(8'h03, 32'd4, 0, "count_th_rst");
      expectRead(8'h13, 32'd0, 0, "hist3_rst");
      runTable();
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk);
      #1 checkOutput("tready_after_reset", {31'b0, tready}, 32'd1);

      // Two 4x3 frames of class 3, then a frame-opening beat with a same-cycle read.
      sendFrame(4, 3, 0, 3, 8, 1'b1, 1'b0);
      sendFrame(4, 3, 0, 3, 8, 1'b1, 1'b0);
      @(negedge aclk);
      tuser = 1'b1; tlast = 1'b0; tnumber = 4'd3; tcount = 4'd3; tdetection = 1'b1; tvalid = 1'b1;
      wb_adr = 8'h01; wb_we = 1'b0; wb_stb = 1'b1;
      #1 checkOutput("fc_same_cycle_old", wb_dat, 32'd1);
      @(posedge aclk);
      #1 checkOutput("fc_after_latch", wb_dat, 32'd2);
      tvalid = 1'b0; wb_stb = 1'b0;
      expectRead(8'h13, 32'd12, 0, "hist3_frame");
      expectRead(8'h05, 32'd12, 0, "pixels_frame");
      expectRead(8'h04, 32'd3, 0, "lines_frame");
      expectRead(8'h00, 32'd1, 0, "status_valid");
      runTable();

      // Rejected beats only: low count, background class, no detection.
      sendFrame(4, 3, 1, 3, 8, 1'b1, 1'b1);
      sendFrame(4, 3, 0, 5, 8, 1'b1, 1'b0);
      expectRead(8'h01, 32'd3, 0, "fc_rejects");
      expectRead(8'h13, 32'd0, 0, "hist3_rejects");
      expectRead(8'h10, 32'd0, 0, "hist0_rejects");
      expectRead(8'h05, 32'd12, 0, "pixels_rejects");
      expectRead(8'h04, 32'd3, 0, "lines_rejects");
      runTable();

      // Freeze holds the class-5 frame while the next frame closes.
      sendFrame(4, 2, 0, 5, 8, 1'b1, 1'b0);
      expectRead(8'h15, 32'd12, 0, "hist5_frame1");
      expectRead(8'h01, 32'd4, 0, "fc_frame1");
      runTable();
      wbWrite(8'h02, 32'd3, 4'b0001);
      sendFrame(4, 2, 0, 2, 8, 1'b1, 1'b0);
      expectRead(8'h15, 32'd12, 0, "hist5_frozen");
      expectRead(8'h12, 32'd0, 0, "hist2_frozen");
      expectRead(8'h01, 32'd4, 0, "fc_frozen");
      expectRead(8'h05, 32'd12, 0, "pixels_frozen");
      expectRead(8'h02, 32'd3, 0, "control_freeze");
      runTable();
      wbWrite(8'h02, 32'd1, 4'b0001);
      sendFrame(5, 4, 0, 1, 8, 1'b1, 1'b0);
      expectRead(8'h12, 32'd8, 0, "hist2_unfrozen");
      expectRead(8'h15, 32'd0, 0, "hist5_unfrozen");
      expectRead(8'h05, 32'd8, 0, "pixels_unfrozen");
      expectRead(8'h04, 32'd2, 0, "lines_unfrozen");
      expectRead(8'h01, 32'd5, 0, "fc_unfrozen");
      runTable();

      // Saturation on the 4-bit instance after 20 counted beats.
      sendFrame(1, 1, 0, 0, 8, 1'b1, 1'b0);
      expectRead(8'h11, 32'd20, 0, "hist1_wide");
      expectRead(8'h05, 32'd20, 0, "pixels_wide");
      expectRead(8'h11, 32'd15, 1, "hist1_sat");
      expectRead(8'h05, 32'd15, 1, "pixels_sat");
      expectRead(8'h04, 32'd4, 1, "lines_narrow");
      expectRead(8'h01, 32'd6, 1, "fc_narrow");
      runTable();

      // Byte-lane writes, read-only writes, and ENABLE gating only the histogram.
      wbWrite(8'h03, 32'h12345678, 4'b0001);
      wbWrite(8'h03, 32'h000000FF, 4'b0010);
      wbWrite(8'h01, 32'h0000DEAD, 4'b1111);
      wbWrite(8'h02, 32'hFFFFFFFC, 4'b1111);
      expectRead(8'h03, 32'd8, 0, "count_th_lane");
      expectRead(8'h01, 32'd6, 0, "fc_ro_write");
      expectRead(8'h02, 32'd0, 0, "control_upper_ignored");
      expectRead(8'h20, 32'd0, 0, "unmapped");
      runTable();
      sendFrame(4, 1, 1, 1, 8, 1'b1, 1'b0);
      sendFrame(1, 1, 0, 0, 8, 1'b1, 1'b0);
      expectRead(8'h10, 32'd1, 0, "hist0_enabled_part");
      expectRead(8'h11, 32'd0, 0, "hist1_disabled");
      expectRead(8'h05, 32'd4, 0, "pixels_disabled");
      expectRead(8'h04, 32'd2, 0, "lines_disabled");
      expectRead(8'h01, 32'd7, 0, "fc_disabled");
      runTable();
      wbWrite(8'h02, 32'd1, 4'b0001);
      wbWrite(8'h03, 32'd4, 4'b0001);

      // Reset mid-frame, then stray beats before the next frame start.
      sendFrame(4, 1, 1, 7, 8, 1'b1, 1'b0);
      @(negedge aclk);
      aresetn = 1'b0;
      #1 checkOutput("tready_mid_reset", {31'b0, tready}, 32'd0);
      expectRead(8'h00, 32'd0, 0, "status_mid_reset");
      expectRead(8'h01, 32'd0, 0, "fc_mid_reset");
      expectRead(8'h02, 32'd1, 0, "control_mid_reset");
      expectRead(8'h03, 32'd4, 0, "count_th_mid_reset");
      expectRead(8'h10, 32'd0, 0, "hist0_mid_reset");
      expectRead(8'h05, 32'd0, 0, "pixels_mid_reset");
      runTable();
      @(negedge aclk);
      aresetn = 1'b1;
      @(posedge aclk);
      #1 checkOutput("tready_rerelease", {31'b0, tready}, 32'd1);
      sendFrame(6, 1, 1, 7, 8, 1'b1, 1'b0);
      sendFrame(4, 3, 0, 7, 8, 1'b1, 1'b0);
      expectRead(8'h00, 32'd0, 0, "status_first_frame");
      runTable();
      sendFrame(1, 1, 0, 0, 8, 1'b1, 1'b0);
      expectRead(8'h17, 32'd12, 0, "hist7_no_prestart");
      expectRead(8'h05, 32'd12, 0, "pixels_no_prestart");
      expectRead(8'h04, 32'd3, 0, "lines_no_prestart");
      expectRead(8'h01, 32'd1, 0, "fc_no_prestart");
      expectRead(8'h00, 32'd1, 0, "status_no_prestart");
      runTable();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
